vga_sync_decoder: RTL and testbench

- Receive-side counterpart of the VGA timing generator. Consumes active-low hsync/vsync plus the active-video qualifier, all synchronous to clk.
- Recovers per-pixel coordinates, measures line and frame timing, and declares lock once the incoming raster matches the expected geometry.
- Sits at the front of capture and monitor paths: frame grabber, loopback checker, on-screen diagnostics.

---
 rtl/vga_sync_decoder.sv | 198 +++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA receive-side sync decoder: pixel coordinates, line/frame timing, raster lock
// Registers hsync/vsync/DE once, derives edges from the previous samples, and locks after LOCK_FRAMES good frames.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 768,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        active_video,
  output logic [10:0] pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pix_valid,
  output logic        frame_start,
  output logic [10:0] h_total,
  output logic [10:0] h_active,
  output logic [9:0]  v_active,
  output logic        locked,
  output logic        sync_lost
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam int IW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic          hs_r, vs_r, de_r;
  logic          hs_p, vs_p, de_p;
  logic          hs_fall, vs_fall, de_fall;
  logic [10:0]   hcnt;
  logic          h_armed;
  logic [9:0]    line_cnt;
  logic          frame_good;
  logic [3:0]    good_cnt;
  logic [1:0]    state;
  logic [IW-1:0] idle_cnt;
  logic          lost;

  logic [10:0]   run_len;
  logic          run_ok;
  logic [9:0]    lines_now;
  logic          frame_ok;
  logic          timeout;
  logic [3:0]    good_nxt;
  logic [10:0]   h_meas;

  assign hs_fall = hs_p & ~hs_r;
  assign vs_fall = vs_p & ~vs_r;
  assign de_fall = de_p & ~de_r;

  always_comb begin
    run_len   = (pixel_x == 11'h7FF) ? 11'h7FF : pixel_x + 11'd1;
    run_ok    = (run_len == 11'(H_ACTIVE));
    lines_now = line_cnt;
    if (de_fall && line_cnt != 10'h3FF)
      lines_now = line_cnt + 10'd1;
    // a run ending on the vsync-fall cycle still belongs to the frame being judged
    frame_ok  = frame_good && (!de_fall || run_ok) && (lines_now == 10'(V_ACTIVE));
    timeout   = !lost && (idle_cnt == IW'(TIMEOUT - 1));
    good_nxt  = (good_cnt == 4'hF) ? 4'hF : good_cnt + 4'd1;
    h_meas    = (hcnt == 11'h7FF) ? 11'h7FF : hcnt + 11'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_r      <= 1'b0;
      vs_r      <= 1'b0;
      de_r      <= 1'b0;
      hs_p      <= 1'b0;
      vs_p      <= 1'b0;
      de_p      <= 1'b0;
      pix_valid <= 1'b0;
      pixel_x   <= 11'd0;
      pixel_y   <= 10'd0;
      line_cnt  <= 10'd0;
    end else begin
      hs_r      <= hsync;
      vs_r      <= vsync;
      de_r      <= active_video;
      hs_p      <= hs_r;
      vs_p      <= vs_r;
      de_p      <= de_r;
      pix_valid <= de_r;
      if (!de_r)
        pixel_x <= 11'd0;
      else if (!pix_valid)
        pixel_x <= 11'd0;
      else if (pixel_x != 11'h7FF)
        pixel_x <= pixel_x + 11'd1;
      if (!de_r || vs_fall)
        pixel_y <= 10'd0;
      else
        pixel_y <= line_cnt;
      if (vs_fall)
        line_cnt <= 10'd0;
      else if (de_fall && line_cnt != 10'h3FF)
        line_cnt <= line_cnt + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt        <= 11'd0;
      h_armed     <= 1'b0;
      frame_good  <= 1'b0;
      good_cnt    <= 4'd0;
      state       <= ST_SEARCH;
      idle_cnt    <= '0;
      lost        <= 1'b0;
      frame_start <= 1'b0;
      sync_lost   <= 1'b0;
      h_total     <= 11'd0;
      h_active    <= 11'd0;
      v_active    <= 10'd0;
      locked      <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      sync_lost   <= 1'b0;
      if (hs_fall)
        hcnt <= 11'd0;
      else if (hcnt != 11'h7FF)
        hcnt <= hcnt + 11'd1;

      if (timeout) begin
        // counter parks at TIMEOUT-1 so a dead input reports loss only once
        lost      <= 1'b1;
        sync_lost <= 1'b1;
        state     <= ST_SEARCH;
        good_cnt  <= 4'd0;
        h_armed   <= 1'b0;
        locked    <= 1'b0;
        h_total   <= 11'd0;
        h_active  <= 11'd0;
        v_active  <= 10'd0;
      end else begin
        if (hs_fall || vs_fall) begin
          idle_cnt <= '0;
          lost     <= 1'b0;
        end else if (!lost) begin
          idle_cnt <= idle_cnt + 1'b1;
        end

        if (hs_fall) begin
          if (h_armed)
            h_total <= h_meas;
          h_armed <= 1'b1;
        end

        if (de_fall) begin
          h_active <= run_len;
          if (!run_ok)
            frame_good <= 1'b0;
        end

        if (vs_fall) begin
          frame_start <= 1'b1;
          frame_good  <= 1'b1;
          if (state != ST_SEARCH)
            v_active <= lines_now;
          case (state)
            ST_SEARCH: begin
              state    <= ST_ACQUIRE;
              good_cnt <= 4'd0;
            end
            ST_ACQUIRE: begin
              if (frame_ok) begin
                good_cnt <= good_nxt;
                if (good_nxt >= 4'(LOCK_FRAMES)) begin
                  state  <= ST_LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                good_cnt <= 4'd0;
              end
            end
            ST_LOCKED: begin
              if (!frame_ok) begin
                state    <= ST_ACQUIRE;
                good_cnt <= 4'd0;
                locked   <= 1'b0;
              end
            end
            default: begin
              state    <= ST_SEARCH;
              good_cnt <= 4'd0;
              locked   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - scoreboard bench for vga_sync_decoder on a reduced 16x6 raster
// Raster: 24 clocks per line (16 DE, hsync low 18..20), 9 lines per frame, vsync low on line 7.
module tb_vga_sync_decoder;

  localparam int HA  = 16;
  localparam int VA  = 6;
  localparam int HT  = 24;
  localparam int TMO = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        active_video = 1'b0;
  logic [10:0] pixel_x;
  logic [9:0]  pixel_y;
  logic        pix_valid;
  logic        frame_start;
  logic [10:0] h_total;
  logic [10:0] h_active;
  logic [9:0]  v_active;
  logic        locked;
  logic        sync_lost;

  int checks = 0;
  int errors = 0;
  int fs_cnt = 0;
  int sl_cnt = 0;
  int exp_fs = 0;
  logic [31:0] pix_q[$];

  vga_sync_decoder #(.H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .active_video(active_video),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pix_valid(pix_valid), .frame_start(frame_start),
    .h_total(h_total), .h_active(h_active), .v_active(v_active), .locked(locked),
    .sync_lost(sync_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      logic [31:0] e;
      if (frame_start) fs_cnt++;
      if (sync_lost) sl_cnt++;
      if (pix_valid) begin
        e = (pix_q.size() > 0) ? pix_q.pop_front() : 32'hFFFF_FFFF;
        check("pixel_xy", 32'({pixel_y, pixel_x}), e);
      end else begin
        check("pixel_idle", 32'({pixel_y, pixel_x}), 32'd0);
      end
    end
  end

  task automatic line(input int row, input int de_len, input bit vs);
    for (int c = 0; c < HT; c++) begin
      active_video = (c < de_len);
      hsync = !(c >= 18 && c < 21);
      vsync = vs;
      if (c < de_len) pix_q.push_back(32'((row << 11) | c));
      @(posedge clk); #1;
    end
  endtask

  task automatic frame(input int n_act, input int short_l, input int short_len, input bit arm_chk);
    for (int l = 0; l < 9; l++) begin
      int dl = (l < n_act) ? ((l == short_l) ? short_len : HA) : 0;
      line(l, dl, (l == 7) ? 1'b0 : 1'b1);
      if (arm_chk && l == 0) check("h_total_arm", 32'(h_total), 32'd0);
      if (arm_chk && l == 1) check("h_total_first", 32'(h_total), HT);
      if (l == short_l && l < n_act) check("h_active_short", 32'(h_active), 32'(short_len));
    end
    exp_fs++;
    check("frame_start_cnt", 32'(fs_cnt), 32'(exp_fs));
  endtask

  task automatic idle_syncs(input int n);
    active_video = 1'b0; hsync = 1'b1; vsync = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_outputs", 32'({pix_valid, frame_start, locked, sync_lost, pixel_x, pixel_y}), 32'd0);
    check("rst_meas", 32'({h_total, h_active, v_active}), 32'd0);

    // initial acquisition: arming frame plus two good frames
    frame(VA, -1, 0, 1'b1);
    check("lock_f1", 32'(locked), 32'd0);
    check("v_active_f1", 32'(v_active), 32'd0);
    frame(VA, -1, 0, 1'b0);
    check("lock_f2", 32'(locked), 32'd0);
    check("v_active_f2", 32'(v_active), VA);
    frame(VA, -1, 0, 1'b0);
    check("lock_f3", 32'(locked), 32'd1);
    check("h_total", 32'(h_total), HT);
    check("h_active", 32'(h_active), HA);
    check("v_active", 32'(v_active), VA);

    // one short DE run drops lock, two good frames restore it
    frame(VA, 2, 13, 1'b0);
    check("lock_short_run", 32'(locked), 32'd0);
    frame(VA, -1, 0, 1'b0);
    check("relock_1", 32'(locked), 32'd0);
    frame(VA, -1, 0, 1'b0);
    check("relock_2", 32'(locked), 32'd1);
    check("sync_lost_none", 32'(sl_cnt), 32'd0);

    // loss of signal
    idle_syncs(TMO + 20);
    check("sync_lost_once", 32'(sl_cnt), 32'd1);
    check("tmo_locked", 32'(locked), 32'd0);
    check("tmo_meas", 32'({h_total, h_active, v_active}), 32'd0);
    frame(VA, -1, 0, 1'b1);
    check("tmo_v_active", 32'(v_active), 32'd0);
    frame(VA, -1, 0, 1'b0);
    check("tmo_relock_1", 32'(locked), 32'd0);
    frame(VA, -1, 0, 1'b0);
    check("tmo_relock_2", 32'(locked), 32'd1);

    // frame one line short
    frame(VA - 1, -1, 0, 1'b0);
    check("short_v_active", 32'(v_active), VA - 1);
    check("short_lock", 32'(locked), 32'd0);
    frame(VA, -1, 0, 1'b0);
    check("short_good1", 32'(locked), 32'd0);
    frame(VA, -1, 0, 1'b0);
    check("short_good2", 32'(locked), 32'd1);

    // reset mid-line while locked
    line(0, HA, 1'b1);
    line(1, HA, 1'b1);
    for (int c = 0; c < 8; c++) begin
      active_video = 1'b1; hsync = 1'b1; vsync = 1'b1;
      pix_q.push_back(32'((2 << 11) | c));
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    check("midrst_outputs", 32'({pix_valid, frame_start, locked, sync_lost, pixel_x, pixel_y}), 32'd0);
    check("midrst_meas", 32'({h_total, h_active, v_active}), 32'd0);
    active_video = 1'b0;
    pix_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    pix_q.delete();
    frame(VA, -1, 0, 1'b1);
    check("rst_lock_f1", 32'(locked), 32'd0);
    check("rst_v_active_f1", 32'(v_active), 32'd0);
    frame(VA, -1, 0, 1'b0);
    check("rst_lock_f2", 32'(locked), 32'd0);
    check("rst_v_active_f2", 32'(v_active), VA);
    frame(VA, -1, 0, 1'b0);
    check("rst_lock_f3", 32'(locked), 32'd1);

    idle_syncs(4);
    check("pix_queue_empty", 32'(pix_q.size()), 32'd0);
    check("sync_lost_total", 32'(sl_cnt), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
